// File: rtl/aes_pkg.sv
// Shared AES-128 definitions: controller FSM encoding, sizes, byte/column types
// and the GF(2^8) arithmetic helpers used by the round datapath.
package aes_pkg;

  localparam int unsigned NUM_ROUNDS = 10;
  localparam int unsigned KEY_W      = 128;
  localparam int unsigned BLOCK_W    = 128;
  localparam int unsigned RND_W      = 4;
  localparam int unsigned NUM_BYTES  = BLOCK_W / 8;
  localparam int unsigned NUM_COLS   = 4;

  typedef logic [7:0]  byte_t;
  typedef logic [31:0] col_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_DONE  = 2'd2
  } fsm_e;

  // Multiply by x modulo the AES polynomial x^8 + x^4 + x^3 + x + 1.
  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic byte_t gf_mul(input byte_t a, input byte_t b);
    byte_t acc;
    byte_t x;
    acc = 8'h00;
    x   = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ x;
      x = xtime(x);
    end
    return acc;
  endfunction

endpackage

// File: rtl/aes_round.sv
// One combinational AES encryption round; the last round skips MixColumns.
module aes_round
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] state,
  input  logic [KEY_W-1:0]   round_key,
  input  logic               final_round,
  output logic [BLOCK_W-1:0] next_state
);

  logic [BLOCK_W-1:0] sb;
  logic [BLOCK_W-1:0] sr;
  logic [BLOCK_W-1:0] mc;

  sub_bytes   u_sub_bytes   (.din(state), .dout(sb));
  shift_rows  u_shift_rows  (.din(sb),    .dout(sr));
  mix_columns u_mix_columns (.din(sr),    .dout(mc));

  assign next_state = (final_round ? sr : mc) ^ round_key;

endmodule

// File: rtl/mix_columns.sv
// MixColumns: each 32-bit column is multiplied by the fixed AES matrix.
module mix_columns
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] din,
  output logic [BLOCK_W-1:0] dout
);

  function automatic col_t mix_col(input col_t a);
    byte_t a0, a1, a2, a3;
    {a0, a1, a2, a3} = a;
    return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
            a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
            a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
            xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
  endfunction

  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    assign dout[BLOCK_W-1-32*c -: 32] = mix_col(din[BLOCK_W-1-32*c -: 32]);
  end

endmodule

// File: rtl/shift_rows.sv
// ShiftRows: row r of the column-major state is rotated left by r bytes.
module shift_rows
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] din,
  output logic [BLOCK_W-1:0] dout
);

  // Byte 0 sits in the top bits; byte index is 4*column + row.
  for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int unsigned DST = 4*c + r;
      localparam int unsigned SRC = 4*((c + r) % NUM_COLS) + r;
      assign dout[BLOCK_W-1-8*DST -: 8] = din[BLOCK_W-1-8*SRC -: 8];
    end
  end

endmodule

// File: rtl/sub_bytes.sv
// SubBytes: every byte goes through the AES S-box, built as GF(2^8)
// inversion followed by the affine map.
module sub_bytes
  import aes_pkg::*;
(
  input  logic [BLOCK_W-1:0] din,
  output logic [BLOCK_W-1:0] dout
);

  // a^254 is the multiplicative inverse (and maps 0 to 0).
  function automatic byte_t sbox(input byte_t a);
    byte_t sq;
    byte_t inv;
    sq  = a;
    inv = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  for (genvar i = 0; i < NUM_BYTES; i++) begin : g_byte
    assign dout[8*i +: 8] = sbox(din[8*i +: 8]);
  end

endmodule

// File: rtl/aes_enc_ctrl.sv
// AES-128 iterative encryption controller: one round per cycle, round keys
// supplied by an external schedule indexed by rnd_idx.
module aes_enc_ctrl #(
  parameter int unsigned NUM_ROUNDS = aes_pkg::NUM_ROUNDS
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic [aes_pkg::BLOCK_W-1:0]  din,
  input  logic                         abort,
  input  logic [aes_pkg::KEY_W-1:0]    round_key,
  output logic [aes_pkg::RND_W-1:0]    rnd_idx,
  output logic                         busy,
  output logic                         done,
  output logic [aes_pkg::BLOCK_W-1:0]  dout
);

  localparam int unsigned BW = aes_pkg::BLOCK_W;
  localparam int unsigned RW = aes_pkg::RND_W;

  aes_pkg::fsm_e fsm_q, fsm_d;
  logic [BW-1:0] state_q, state_d;
  logic [BW-1:0] dout_d;
  logic [BW-1:0] round_out;
  logic [RW-1:0] rnd_d;
  logic          busy_d;
  logic          done_d;
  logic          last_rnd;

  assign last_rnd = (rnd_idx == RW'(NUM_ROUNDS));

  aes_round u_aes_round (
    .state       (state_q),
    .round_key   (round_key),
    .final_round (last_rnd),
    .next_state  (round_out)
  );

  // Next-state and registered-output decode; abort outranks start and rounds.
  always_comb begin
    fsm_d   = fsm_q;
    state_d = state_q;
    dout_d  = dout;
    rnd_d   = '0;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    unique case (fsm_q)
      aes_pkg::ST_IDLE, aes_pkg::ST_DONE: begin
        fsm_d = aes_pkg::ST_IDLE;
        if (start && !abort) begin
          fsm_d   = aes_pkg::ST_ROUND;
          state_d = din ^ round_key;
          rnd_d   = RW'(1);
          busy_d  = 1'b1;
        end
      end
      aes_pkg::ST_ROUND: begin
        if (abort) begin
          fsm_d = aes_pkg::ST_IDLE;
        end else begin
          state_d = round_out;
          if (last_rnd) begin
            fsm_d  = aes_pkg::ST_DONE;
            dout_d = round_out;
            done_d = 1'b1;
          end else begin
            rnd_d  = rnd_idx + RW'(1);
            busy_d = 1'b1;
          end
        end
      end
      default: fsm_d = aes_pkg::ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q   <= aes_pkg::ST_IDLE;
      state_q <= '0;
      dout    <= '0;
      rnd_idx <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      dout    <= dout_d;
      rnd_idx <= rnd_d;
      busy    <= busy_d;
      done    <= done_d;
    end
  end

endmodule
